// File: rtl/pixel_sram_responder.sv
// pixel_sram_responder
//   Bus responder for the on-chip pixel SRAM. It takes single-beat byte reads and
//   writes from the drawing master and answers each with a one-cycle bus_ack. A
//   separate read-only scan port serves the VGA side.
// Ports
//   clock, reset        system clock; synchronous active-low reset
//   bus_addr/_read/...  master request: byte address, level read/write requests, lane enables, data
//   bus_read_data       {24'b0, pixel}; valid while bus_ack is high
//   bus_ack             one-cycle completion pulse
//   scan_x/scan_y       scan-out coordinate; scan_data follows one cycle later
//   err_count           saturating count of rejected accesses
module pixel_sram_responder #(
  parameter logic [31:0] VIDEO_BASE = 32'h0800_0000,
  parameter int unsigned X_BITS     = 10,
  parameter int unsigned Y_BITS     = 9,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       bus_addr,
  input  logic [3:0]        bus_byte_enable,
  input  logic              bus_read,
  input  logic              bus_write,
  input  logic [31:0]       bus_write_data,
  output logic [31:0]       bus_read_data,
  output logic              bus_ack,
  input  logic [X_BITS-1:0] scan_x,
  input  logic [Y_BITS-1:0] scan_y,
  output logic [7:0]        scan_data,
  output logic [15:0]       err_count
);

  localparam int unsigned A_BITS = X_BITS + Y_BITS;
  localparam int unsigned DEPTH  = V_ACTIVE << X_BITS;
  localparam logic [X_BITS-1:0] H_LIM = X_BITS'(H_ACTIVE);
  localparam logic [Y_BITS-1:0] V_LIM = Y_BITS'(V_ACTIVE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  logic [7:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic [15:0] err_q, err_d;
  logic        rd_ok_q, rd_ok_d;
  logic [7:0]  sram_a_q;
  logic [7:0]  scan_q;

  logic [31:0]       off_c;
  logic [X_BITS-1:0] off_x_c;
  logic [Y_BITS-1:0] off_y_c;
  logic              addr_ok_c;
  logic [A_BITS-1:0] bus_idx_c;
  logic [A_BITS-1:0] scan_idx_c;
  logic              scan_ok_c;
  logic              wr_en_c, rd_en_c;
  logic [15:0]       err_inc_c;

  // Only byte lane 0 carries a pixel; the other lanes are ignored by design.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus_byte_enable[3:1], bus_write_data[31:8]};

  // Address decode: offset from the region base, split into x/y fields.
  assign off_c     = bus_addr - VIDEO_BASE;
  assign off_x_c   = off_c[X_BITS-1:0];
  assign off_y_c   = off_c[A_BITS-1:X_BITS];
  assign addr_ok_c = (off_c[31:A_BITS] == '0) && (off_x_c < H_LIM) && (off_y_c < V_LIM);
  assign bus_idx_c = {off_y_c, off_x_c};

  assign scan_idx_c = {scan_y, scan_x};
  assign scan_ok_c  = (scan_x < H_LIM) && (scan_y < V_LIM);

  assign err_inc_c = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

  // Next-state and SRAM strobe decode; reset suppresses any access in flight.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    rd_ok_d = rd_ok_q;
    wr_en_c = 1'b0;
    rd_en_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus_write) begin
          state_d = S_ACK;
          wr_en_c = reset && addr_ok_c && bus_byte_enable[0];
          if (!addr_ok_c || bus_read) err_d = err_inc_c;
        end else if (bus_read) begin
          state_d = S_RD_WAIT;
          rd_en_c = reset;
          rd_ok_d = addr_ok_c;
          if (!addr_ok_c) err_d = err_inc_c;
        end
      end
      S_RD_WAIT: begin
        rdata_d = rd_ok_q ? {24'd0, sram_a_q} : 32'd0;
        state_d = S_ACK;
      end
      S_ACK: state_d = S_RELEASE;
      // Hold here until the master drops its request so a held request commits once.
      S_RELEASE: if (!bus_read && !bus_write) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ack_d = (state_d == S_ACK);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 16'd0;
      rd_ok_q <= 1'b0;
      scan_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
      scan_q  <= scan_ok_c ? mem[scan_idx_c] : 8'd0;
    end
  end

  // Pixel storage: port A bus read/write, port B scan read (old data on collision).
  always_ff @(posedge clock) begin
    if (wr_en_c) mem[bus_idx_c] <= bus_write_data[7:0];
    if (rd_en_c) sram_a_q <= mem[bus_idx_c];
  end

  assign bus_read_data = rdata_q;
  assign bus_ack       = ack_q;
  assign scan_data     = scan_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_pixel_sram_responder.sv
// Directed bench for pixel_sram_responder: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_pixel_sram_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byte_enable;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_ack;
  logic [9:0]  scan_x;
  logic [8:0]  scan_y;
  logic [7:0]  scan_data;
  logic [15:0] err_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  pixel_sram_responder dut (
    .clock          (clock),
    .reset          (reset),
    .bus_addr       (bus_addr),
    .bus_byte_enable(bus_byte_enable),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_write_data (bus_write_data),
    .bus_read_data  (bus_read_data),
    .bus_ack        (bus_ack),
    .scan_x         (scan_x),
    .scan_y         (scan_y),
    .scan_data      (scan_data),
    .err_count      (err_count)
  );

  always #5 clock = ~clock;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drop requests and let the FSM pass ACK -> RELEASE -> IDLE.
  task automatic idle_bus();
    bus_read  = 1'b0;
    bus_write = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_addr = 32'd0; bus_byte_enable = 4'd0; bus_read = 1'b0; bus_write = 1'b0;
    bus_write_data = 32'd0; scan_x = 10'd0; scan_y = 9'd0;
    tick();
    tick();
    total_cnt++;
    if (bus_ack !== 1'b0) $display("FAIL rst_ack: got %0b exp 0", bus_ack); else pass_cnt++;
    total_cnt++;
    if (err_count !== 16'd0) $display("FAIL rst_err: got %0h exp 0", err_count); else pass_cnt++;
    total_cnt++;
    if (bus_read_data !== 32'd0) $display("FAIL rst_rdata: got %h exp 0", bus_read_data); else pass_cnt++;
    total_cnt++;
    if (scan_data !== 8'd0) $display("FAIL rst_scan: got %h exp 0", scan_data); else pass_cnt++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_write();
    bus_addr = 32'h0800_0005; bus_write_data = 32'h0000_00FF; bus_byte_enable = 4'b0001;
    bus_write = 1'b1;
    tick();
    total_cnt++;
    if (bus_ack !== 1'b1) $display("FAIL wr_ack: got %0b exp 1", bus_ack); else pass_cnt++;
    bus_write = 1'b0;
    tick();
    total_cnt++;
    if (bus_ack !== 1'b0) $display("FAIL wr_ack_pulse: got %0b exp 0", bus_ack); else pass_cnt++;
    tick();
    scan_x = 10'd5; scan_y = 9'd0;
    tick();
    total_cnt++;
    if (scan_data !== 8'hFF) $display("FAIL wr_scan: got %h exp ff", scan_data); else pass_cnt++;
  endtask

  task automatic test_read();
    bus_addr = 32'h0800_0405; bus_write_data = 32'h0000_003C; bus_byte_enable = 4'b0001;
    bus_write = 1'b1;
    tick();
    idle_bus();
    bus_read = 1'b1;
    tick();
    total_cnt++;
    if (bus_ack !== 1'b0) $display("FAIL rd_early_ack: got %0b exp 0", bus_ack); else pass_cnt++;
    tick();
    total_cnt++;
    if (bus_ack !== 1'b1) $display("FAIL rd_ack: got %0b exp 1", bus_ack); else pass_cnt++;
    total_cnt++;
    if (bus_read_data !== 32'h0000_003C) $display("FAIL rd_data: got %h exp 0000003c", bus_read_data);
    else pass_cnt++;
    idle_bus();
    total_cnt++;
    if (bus_read_data !== 32'h0000_003C) $display("FAIL rd_data_hold: got %h exp 0000003c", bus_read_data);
    else pass_cnt++;
  endtask

  task automatic test_held_write();
    int acks;
    acks = 0;
    bus_addr = 32'h0800_0001; bus_write_data = 32'h11; bus_byte_enable = 4'b0001;
    scan_x = 10'd1; scan_y = 9'd0;
    bus_write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_ack === 1'b1) acks++;
    end
    total_cnt++;
    if (acks != 1) $display("FAIL held_acks: got %0d exp 1", acks); else pass_cnt++;
    bus_write_data = 32'h22;
    tick();
    total_cnt++;
    if (bus_ack !== 1'b0) $display("FAIL held_no_reaccept: got %0b exp 0", bus_ack); else pass_cnt++;
    tick();
    total_cnt++;
    if (scan_data !== 8'h11) $display("FAIL held_mem: got %h exp 11", scan_data); else pass_cnt++;
    bus_write = 1'b0;
    tick();
    bus_write = 1'b1;
    tick();
    total_cnt++;
    if (bus_ack !== 1'b1) $display("FAIL held_next_ack: got %0b exp 1", bus_ack); else pass_cnt++;
    idle_bus();
    total_cnt++;
    if (scan_data !== 8'h22) $display("FAIL held_next_mem: got %h exp 22", scan_data); else pass_cnt++;
  endtask

  task automatic test_byte_enable();
    bus_addr = 32'h0800_0004; bus_write_data = 32'h12; bus_byte_enable = 4'b0001;
    bus_write = 1'b1;
    tick();
    idle_bus();
    bus_write_data = 32'h99; bus_byte_enable = 4'b0000;
    bus_write = 1'b1;
    tick();
    total_cnt++;
    if (bus_ack !== 1'b1) $display("FAIL be0_ack: got %0b exp 1", bus_ack); else pass_cnt++;
    idle_bus();
    scan_x = 10'd4; scan_y = 9'd0;
    tick();
    total_cnt++;
    if (scan_data !== 8'h12) $display("FAIL be0_mem: got %h exp 12", scan_data); else pass_cnt++;
    total_cnt++;
    if (err_count !== 16'd0) $display("FAIL be0_err: got %0d exp 0", err_count); else pass_cnt++;
  endtask

  task automatic test_errors();
    // x = 640 is just past the active line.
    bus_addr = 32'h0800_0280; bus_write_data = 32'h55; bus_byte_enable = 4'b0001;
    bus_write = 1'b1;
    tick();
    total_cnt++;
    if (bus_ack !== 1'b1) $display("FAIL err_x_ack: got %0b exp 1", bus_ack); else pass_cnt++;
    idle_bus();
    bus_addr = 32'h0900_0000;
    bus_write = 1'b1;
    tick();
    total_cnt++;
    if (bus_ack !== 1'b1) $display("FAIL err_far_ack: got %0b exp 1", bus_ack); else pass_cnt++;
    idle_bus();
    total_cnt++;
    if (err_count !== 16'd2) $display("FAIL err_cnt2: got %0d exp 2", err_count); else pass_cnt++;
    // x = 640 aliases nothing: (0,1) keeps its value and the line start is unchanged.
    scan_x = 10'd5; scan_y = 9'd0;
    tick();
    total_cnt++;
    if (scan_data !== 8'hFF) $display("FAIL err_mem: got %h exp ff", scan_data); else pass_cnt++;
    // Read and write together: write path wins (1-cycle ack) and counts as an error.
    bus_addr = 32'h0800_0003; bus_write_data = 32'h77;
    bus_read = 1'b1; bus_write = 1'b1;
    tick();
    total_cnt++;
    if (bus_ack !== 1'b1) $display("FAIL rw_ack: got %0b exp 1", bus_ack); else pass_cnt++;
    idle_bus();
    total_cnt++;
    if (err_count !== 16'd3) $display("FAIL rw_err: got %0d exp 3", err_count); else pass_cnt++;
    scan_x = 10'd3;
    tick();
    total_cnt++;
    if (scan_data !== 8'h77) $display("FAIL rw_mem: got %h exp 77", scan_data); else pass_cnt++;
    // Invalid read returns zero.
    bus_addr = 32'h0900_0000;
    bus_read = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (bus_ack !== 1'b1 || bus_read_data !== 32'd0)
      $display("FAIL bad_rd: got ack=%0b data=%h exp ack=1 data=0", bus_ack, bus_read_data);
    else pass_cnt++;
    idle_bus();
    total_cnt++;
    if (err_count !== 16'd4) $display("FAIL bad_rd_err: got %0d exp 4", err_count); else pass_cnt++;
  endtask

  task automatic test_collision();
    bus_addr = 32'h0800_0807; bus_write_data = 32'h10; bus_byte_enable = 4'b0001;
    bus_write = 1'b1;
    tick();
    idle_bus();
    bus_write_data = 32'hAA;
    scan_x = 10'd7; scan_y = 9'd2;
    bus_write = 1'b1;
    tick();
    total_cnt++;
    if (scan_data !== 8'h10) $display("FAIL coll_old: got %h exp 10", scan_data); else pass_cnt++;
    bus_write = 1'b0;
    tick();
    total_cnt++;
    if (scan_data !== 8'hAA) $display("FAIL coll_new: got %h exp aa", scan_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_read();
    int acks;
    acks = 0;
    bus_addr = 32'h0800_0405;
    bus_read = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if (bus_ack !== 1'b0) $display("FAIL rst_rd_ack: got %0b exp 0", bus_ack); else pass_cnt++;
    total_cnt++;
    if (err_count !== 16'd0) $display("FAIL rst_rd_err: got %0d exp 0", err_count); else pass_cnt++;
    reset = 1'b1;
    bus_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus_ack === 1'b1) acks++;
    end
    total_cnt++;
    if (acks != 0) $display("FAIL rst_rd_dropped: got %0d acks exp 0", acks); else pass_cnt++;
    // FSM must be back in IDLE: a write acks after one cycle.
    bus_addr = 32'h0800_0000; bus_write_data = 32'h01;
    bus_write = 1'b1;
    tick();
    total_cnt++;
    if (bus_ack !== 1'b1) $display("FAIL rst_rd_idle: got %0b exp 1", bus_ack); else pass_cnt++;
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_held_write();
    test_byte_enable();
    test_errors();
    test_collision();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
